// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes processor accesses into RAM, LED/HEX/switch ports and an interval timer.
// Read data returns exactly one clock after the address is presented.
module mem_io_bridge #(
    parameter int          RAM_AW   = 8,
    parameter logic [15:0] PRESCALE = 16'd50000
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [15:0]       ADDR,
    input  logic [15:0]       DOUT,
    input  logic              W,
    output logic [15:0]       DIN,
    input  logic [15:0]       ram_q,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_data,
    output logic              ram_wren,
    input  logic [9:0]        SW,
    output logic [9:0]        LEDR,
    output logic [41:0]       HEX
);
    localparam logic [15:0] PRE_MAX = PRESCALE - 16'd1;

    logic [3:0]  w_region;
    logic        w_wr_led, w_wr_hex, w_wr_ctrl, w_wr_load, w_wr_status;
    logic        w_tick, w_timeout_set;
    logic [15:0] w_tmr_rd, w_rword;
    logic        w_unused;

    logic [9:0]  r_sw_meta, r_sw_sync, r_ledr;
    logic [6:0]  r_hex [6];
    logic        r_sel_ram;
    logic [15:0] r_rdata;
    logic        r_run, r_auto, r_timeout;
    logic [15:0] r_load, r_count, r_pre;

    assign w_region    = ADDR[15:12];
    assign w_wr_led    = W && w_region == 4'h1;
    assign w_wr_hex    = W && w_region == 4'h2 && ADDR[2:0] < 3'd6;
    assign w_wr_ctrl   = W && w_region == 4'h4 && ADDR[1:0] == 2'd0;
    assign w_wr_load   = W && w_region == 4'h4 && ADDR[1:0] == 2'd1;
    assign w_wr_status = W && w_region == 4'h4 && ADDR[1:0] == 2'd2;
    assign w_unused    = &{1'b0, ADDR[11:RAM_AW]};

    assign ram_addr = ADDR[RAM_AW-1:0];
    assign ram_data = DOUT;
    assign ram_wren = Resetn && W && w_region == 4'h0;

    assign LEDR = r_ledr;
    assign DIN  = r_sel_ram ? ram_q : r_rdata;

    genvar i;
    generate
        for (i = 0; i < 6; i++) begin : g_hex
            assign HEX[7*i +: 7] = r_hex[i];
        end
    endgenerate

    assign w_tick        = r_run && r_pre == 16'd0;
    assign w_timeout_set = w_tick && r_count == 16'd0 && !w_wr_load;

    assign w_tmr_rd = ADDR[1:0] == 2'd0 ? {14'b0, r_auto, r_run} :
                      ADDR[1:0] == 2'd1 ? r_load :
                      ADDR[1:0] == 2'd2 ? {15'b0, r_timeout} : r_count;

    always_comb begin
        w_rword = 16'h0000;
        case (w_region)
            4'h1:    w_rword = {6'b0, r_ledr};
            4'h2:    w_rword = ADDR[2:0] < 3'd6 ? {9'b0, r_hex[ADDR[2:0]]} : 16'h0000;
            4'h3:    w_rword = {6'b0, r_sw_sync};
            4'h4:    w_rword = w_tmr_rd;
            default: w_rword = 16'h0000;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_ledr    <= '0;
            for (int k = 0; k < 6; k++) r_hex[k] <= 7'h7F;
            r_sel_ram <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            if (w_wr_led) r_ledr <= DOUT[9:0];
            if (w_wr_hex) r_hex[ADDR[2:0]] <= DOUT[6:0];
            r_sel_ram <= w_region == 4'h0;
            r_rdata   <= w_rword;
        end
    end

    // A LOAD write overrides any tick landing in the same cycle.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_run     <= 1'b0;
            r_auto    <= 1'b0;
            r_timeout <= 1'b0;
            r_load    <= '0;
            r_count   <= '0;
            r_pre     <= PRE_MAX;
        end else begin
            if (w_wr_load) begin
                r_load  <= DOUT;
                r_count <= DOUT;
                r_pre   <= PRE_MAX;
            end else begin
                if (r_run) r_pre <= w_tick ? PRE_MAX : r_pre - 16'd1;
                if (w_tick) r_count <= r_count != 16'd0 ? r_count - 16'd1 : r_auto ? r_load : r_count;
            end
            if (w_wr_ctrl) begin
                r_run  <= DOUT[0];
                r_auto <= DOUT[1];
            end else if (w_timeout_set && !r_auto) begin
                r_run <= 1'b0;
            end
            if (w_timeout_set) r_timeout <= 1'b1;
            else if (w_wr_status) r_timeout <= 1'b0;
        end
    end
endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Memory/I-O bridge directly downstream of the 16-bit multicycle processor: consumes its ADDR, DOUT and W outputs and produces the DIN it reads. Decodes the 16-bit address space into an external synchronous RAM, a 10-bit LED register, six 7-segment digit registers, a synchronized switch port, and a programmable interval timer. Returns read data with exactly one clock of latency, matching the processor's fetch/load wait cycle.

## Interface
- RAM_AW, 8, RAM word-address width; ram_addr = ADDR[RAM_AW-1:0]
- PRESCALE, 16'd50000, timer clocks per count tick (≥1)
- Clock  in  1  system clock, all state on rising edge
- Resetn  in  1  reset, synchronous, active-low
- ADDR  in  16  processor address, stable the cycle before read data is consumed
- DOUT  in  16  processor write data
- W  in  1  processor write strobe, one cycle, qualified with ADDR/DOUT same cycle
- DIN  out  16  read data to processor
- ram_q  in  16  external synchronous RAM registered output
- ram_addr  out  RAM_AW  RAM address, combinational from ADDR
- ram_data  out  16  RAM write data = DOUT
- ram_wren  out  1  RAM write enable, combinational
- SW  in  10  asynchronous slide switches
- LEDR  out  10  LED register
- HEX  out  42  six 7-bit digit registers, HEX[7i+6:7i] = digit i, segment active-low pass-through

## Operation
- Decode on ADDR[15:12]: 0x0 RAM; 0x1 LEDR; 0x2 HEX (digit = ADDR[2:0], values 6–7 ignored); 0x3 SW (read-only); 0x4 timer (reg = ADDR[1:0]); others unmapped.
- Writes (W=1): RAM → ram_wren=1; LEDR ← DOUT[9:0]; HEX digit ← DOUT[6:0]; SW and unmapped writes ignored.
- Reads: unmapped and writes-only regions return 16'h0000; LEDR read returns {6'b0,LEDR}; HEX read returns {9'b0,digit}; SW returns {6'b0,sw_sync}.
- SW: two-flop synchronizer; sw_sync reset 0.
- Timer registers: 0 CTRL {bit1 auto-reload, bit0 run}; 1 LOAD (16 b); 2 STATUS {bit0 timeout, sticky}, write of any value clears; 3 COUNT (read-only).
- Writing LOAD also sets COUNT=DOUT and resets prescaler to PRESCALE-1.
- Prescaler: while run=1, counts PRESCALE-1 down to 0; tick when 0, then reloads PRESCALE-1. run=0 freezes prescaler and COUNT.
- On tick: COUNT≠0 → COUNT-1. COUNT=0 → timeout←1; auto-reload=1 → COUNT←LOAD, run stays; else run←0, COUNT stays 0.
- Simultaneous STATUS-clear write and timeout set: set wins.
- Simultaneous LOAD write and tick: LOAD write wins, no tick effect.
- CTRL write takes effect next cycle; prescaler not reset by CTRL write.

## Timing
- Reset values: DIN 0, LEDR 0, HEX all 7'h7F (blank), CTRL 0, LOAD 0, STATUS 0, COUNT 0, prescaler PRESCALE-1, sync flops 0, read-select register 0 (unmapped).
- Read latency 1: ADDR=a in cycle k → DIN valid for a throughout cycle k+1. Block registers region select and peripheral read word at end of cycle k; in k+1 DIN = ram_q if select=RAM else registered peripheral word.
- Register read values reflect state before any write in the same cycle k (read-before-write).
- Back-to-back reads at consecutive addresses each return 1 cycle later, no bubbles.
- ram_wren and ram_addr are combinational; RAM write completes at end of the W cycle.
- Reset during a timer run: everything returns to reset values next edge; pending write in reset cycle is discarded.

## Test plan
- Reset, then W=1 ADDR=16'h1000 DOUT=16'h03FF → LEDR=10'h3FF next cycle; read 16'h1000 → DIN=16'h03FF one cycle after.
- Write ADDR=16'h0005 DOUT=16'hBEEF → ram_wren=1, ram_addr=8'h05 same cycle; read 16'h0005 with RAM model → DIN=16'hBEEF one cycle after ADDR.
- SW=10'h2A5 applied → read 16'h3000 returns 16'h02A5 only after two sync edges; read 16'h9000 → DIN=0.
- PRESCALE=2: LOAD=3, CTRL=1 → COUNT 3,2,1,0 every 2 cycles, then timeout=1, run=0, COUNT holds 0; STATUS write → timeout=0.
- PRESCALE=1, LOAD=1, CTRL=3 → timeout every 2 ticks, COUNT reloads 1; STATUS clear on timeout cycle → timeout remains 1.
- Resetn=0 mid-count → COUNT=0, CTRL=0, HEX=all 7'h7F, DIN=0 after the edge.
